// File: rtl/simplerisc_pkg.sv
// Definitions shared across the SimpleRISC core: datapath width, opcode
// encodings and the canonical NOP word emitted by an empty fetch front end.
package simplerisc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [31:0] NOP_INST = {OP_NOP, 27'b0};

  function automatic logic [4:0] opcode_of(input logic [31:0] word);
    return word[31:27];
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory read port between the fetch front end (master) and the
// synchronous instruction memory (slave).
interface fetch_queue_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 7
);
  logic              IMclka;
  logic              IMena;
  logic [ADDR_W-1:0] IMaddra;
  logic [XLEN-1:0]   IMdouta;

  modport master (output IMclka, output IMena, output IMaddra, input IMdouta);
  modport slave  (input IMclka, input IMena, input IMaddra, output IMdouta);
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO with wrap-around pointers and
// a single-cycle flush that empties it regardless of push/pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH) + 1,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign push_ok = push & ~flush;
  assign pop_ok  = pop & ~flush & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage carries no reset; entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_ok && !pop_ok && count == FULL));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues one IM read per cycle while buffer space
// exists, tags reads with their PC and buffers returned words for the IF/OF stage.
module fetch_queue
  import simplerisc_pkg::*;
#(
  parameter int unsigned XLEN       = simplerisc_pkg::XLEN,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IM_LATENCY = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  fetch_queue_if.master    im,
  input  logic             stall,
  input  logic             isBranchTaken,
  input  logic [XLEN-1:0]  branchPC,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  pc,
  output logic             inst_valid,
  output logic [CW-1:0]    occupancy
);

  logic [XLEN-1:0]       fetch_pc;
  logic [IM_LATENCY-1:0] line_valid;
  logic [XLEN-1:0]       line_pc [IM_LATENCY];
  logic [CW:0]           inflight;
  logic [CW:0]           demand;
  logic                  issue;
  logic                  pop;
  logic                  push;
  logic [CW-1:0]         count;
  logic                  empty;
  logic [2*XLEN-1:0]     head;

  assign pop = ~empty & ~stall & ~isBranchTaken;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < IM_LATENCY; i++)
      inflight = inflight + (CW+1)'(line_valid[i]);
  end

  // Reserve a FIFO slot for every outstanding read so returning data always fits.
  assign demand = {1'b0, count} + inflight - (CW+1)'(pop);
  assign issue  = ~rst & ~isBranchTaken & (demand < (CW+1)'(DEPTH));

  assign im.IMclka  = clk;
  assign im.IMena   = issue;
  assign im.IMaddra = fetch_pc[ADDR_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      line_valid <= '0;
      for (int unsigned i = 0; i < IM_LATENCY; i++) line_pc[i] <= '0;
    end else if (isBranchTaken) begin
      fetch_pc   <= branchPC;
      line_valid <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + XLEN'(4);
      line_valid[0] <= issue;
      line_pc[0]    <= fetch_pc;
      for (int unsigned i = 1; i < IM_LATENCY; i++) begin
        line_valid[i] <= line_valid[i-1];
        line_pc[i]    <= line_pc[i-1];
      end
    end
  end

  assign push = line_valid[IM_LATENCY-1] & ~isBranchTaken;

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (isBranchTaken),
    .din   ({im.IMdouta, line_pc[IM_LATENCY-1]}),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  assign inst_valid = ~empty;
  assign inst       = empty ? XLEN'(NOP_INST) : head[2*XLEN-1:XLEN];
  assign pc         = empty ? '0 : head[XLEN-1:0];
  assign occupancy  = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: two instances (IM latency 1 and 3) fed by behavioural
// instruction memories returning word n at word address n.
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  fetch_queue_if #(.XLEN(32), .ADDR_W(7)) im1 ();
  fetch_queue_if #(.XLEN(32), .ADDR_W(7)) im3 ();

  logic        rst1, stall1, br1;
  logic [31:0] bpc1, inst1, pc1;
  logic        valid1;
  logic [2:0]  occ1;

  logic        rst3, stall3, br3;
  logic [31:0] bpc3, inst3, pc3;
  logic        valid3;
  logic [2:0]  occ3;

  fetch_queue #(.XLEN(32), .ADDR_W(7), .DEPTH(4), .IM_LATENCY(1), .RESET_PC(32'h0)) dut1 (
    .clk(clk), .rst(rst1), .im(im1), .stall(stall1), .isBranchTaken(br1),
    .branchPC(bpc1), .inst(inst1), .pc(pc1), .inst_valid(valid1), .occupancy(occ1));

  fetch_queue #(.XLEN(32), .ADDR_W(7), .DEPTH(4), .IM_LATENCY(3), .RESET_PC(32'h0)) dut3 (
    .clk(clk), .rst(rst3), .im(im3), .stall(stall3), .isBranchTaken(br3),
    .branchPC(bpc3), .inst(inst3), .pc(pc3), .inst_valid(valid3), .occupancy(occ3));

  // Unrequested cycles return a poison word so an unqualified push is visible.
  always @(posedge clk)
    im1.IMdouta <= im1.IMena ? 32'(im1.IMaddra) : 32'hBAAD_F00D;

  logic [31:0] d3 [3];
  always @(posedge clk) begin
    d3[0] <= im3.IMena ? 32'(im3.IMaddra) : 32'hBAAD_F00D;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign im3.IMdouta = d3[2];

  logic [31:0] sb1 [$];
  logic [31:0] sb3 [$];

  task automatic sb_load1(input logic [31:0] start);
    sb1.delete();
    for (int i = 0; i < 64; i++) sb1.push_back(start + 32'(4 * i));
  endtask

  task automatic sb_load3(input logic [31:0] start);
    sb3.delete();
    for (int i = 0; i < 64; i++) sb3.push_back(start + 32'(4 * i));
  endtask

  // One clock cycle: compare any instruction the DUTs hand over, then advance.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (!rst1 && valid1 && !stall1 && !br1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++; $display("FAIL sb1_extra pc=%h inst=%h, no instruction expected", pc1, inst1);
      end else begin
        e = sb1.pop_front();
        if (pc1 !== e || inst1 !== ((e >> 2) & 32'd127)) begin
          errors++;
          $display("FAIL sb1_stream pc=%h inst=%h, expected pc=%h inst=%h", pc1, inst1, e, (e >> 2) & 32'd127);
        end
      end
    end
    if (!rst3 && valid3 && !stall3 && !br3) begin
      checks++;
      if (sb3.size() == 0) begin
        errors++; $display("FAIL sb3_extra pc=%h inst=%h, no instruction expected", pc3, inst3);
      end else begin
        e = sb3.pop_front();
        if (pc3 !== e || inst3 !== ((e >> 2) & 32'd127)) begin
          errors++;
          $display("FAIL sb3_stream pc=%h inst=%h, expected pc=%h inst=%h", pc3, inst3, e, (e >> 2) & 32'd127);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    #1;
    checks++;
    if (im1.IMena !== 1'b0 || valid1 !== 1'b0 || occ1 !== 3'd0) begin
      errors++; $display("FAIL reset_ctrl IMena=%b valid=%b occ=%0d, expected 0 0 0", im1.IMena, valid1, occ1);
    end
    checks++;
    if (inst1 !== 32'h6800_0000 || pc1 !== 32'h0) begin
      errors++; $display("FAIL reset_head inst=%h pc=%h, expected 68000000 00000000", inst1, pc1);
    end
    checks++;
    if (im1.IMclka !== clk) begin
      errors++; $display("FAIL imclka got=%b expected=%b", im1.IMclka, clk);
    end
    tick();
  endtask

  task automatic test_release();
    rst1 = 1'b0;
    sb_load1(32'h0);
    #1;
    checks++;
    if (im1.IMena !== 1'b1 || im1.IMaddra !== 7'd0) begin
      errors++; $display("FAIL first_req IMena=%b addr=%0d, expected 1 0", im1.IMena, im1.IMaddra);
    end
    for (int c = 0; c < 14; c++) begin
      if (c > 0) #1;
      checks++;
      if (valid1 !== (c >= 2)) begin
        errors++; $display("FAIL release_valid cycle=%0d got=%b expected=%b", c, valid1, c >= 2);
      end
      if (c == 2) begin
        checks++;
        if (inst1 !== 32'h0 || pc1 !== 32'h0) begin
          errors++; $display("FAIL first_inst inst=%h pc=%h, expected 0 0", inst1, pc1);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    stall1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c >= 3) begin
        checks++;
        if (occ1 !== 3'd4 || im1.IMena !== 1'b0) begin
          errors++; $display("FAIL stall_sat cycle=%0d occ=%0d IMena=%b, expected 4 0", c, occ1, im1.IMena);
        end
      end
      tick();
    end
    stall1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (valid1 !== 1'b1) begin
        errors++; $display("FAIL stall_release_gap cycle=%0d valid=%b, expected 1", c, valid1);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    #1;
    checks++;
    if (occ1 !== 3'd3) begin
      errors++; $display("FAIL branch_pre_occ got=%0d expected=3", occ1);
    end
    br1 = 1'b1; bpc1 = 32'h40;
    sb_load1(32'h40);
    #1;
    checks++;
    if (im1.IMena !== 1'b0) begin
      errors++; $display("FAIL branch_no_issue IMena=%b expected 0", im1.IMena);
    end
    tick();
    br1 = 1'b0;
    #1;
    checks++;
    if (valid1 !== 1'b0 || occ1 !== 3'd0 || im1.IMena !== 1'b1 || im1.IMaddra !== 7'd16) begin
      errors++;
      $display("FAIL branch_f1 valid=%b occ=%0d IMena=%b addr=%0d, expected 0 0 1 16", valid1, occ1, im1.IMena, im1.IMaddra);
    end
    tick();
    #1;
    checks++;
    if (valid1 !== 1'b0) begin
      errors++; $display("FAIL branch_f2 valid=%b expected 0", valid1);
    end
    tick();
    #1;
    checks++;
    if (valid1 !== 1'b1 || inst1 !== 32'd16 || pc1 !== 32'h40) begin
      errors++; $display("FAIL branch_target valid=%b inst=%h pc=%h, expected 1 10 40", valid1, inst1, pc1);
    end
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_branch_stall();
    stall1 = 1'b1; br1 = 1'b1; bpc1 = 32'h100;
    sb_load1(32'h100);
    #1;
    checks++;
    if (im1.IMena !== 1'b0) begin
      errors++; $display("FAIL brstall_issue IMena=%b expected 0", im1.IMena);
    end
    tick();
    stall1 = 1'b0; br1 = 1'b0;
    #1;
    checks++;
    if (occ1 !== 3'd0 || valid1 !== 1'b0) begin
      errors++; $display("FAIL brstall_flush occ=%0d valid=%b, expected 0 0", occ1, valid1);
    end
    tick(); tick();
    #1;
    checks++;
    if (valid1 !== 1'b1 || pc1 !== 32'h100) begin
      errors++; $display("FAIL brstall_target valid=%b pc=%h, expected 1 100", valid1, pc1);
    end
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_wrap();
    br1 = 1'b1; bpc1 = 32'h1FC;
    sb_load1(32'h1FC);
    tick();
    br1 = 1'b0;
    #1;
    checks++;
    if (im1.IMaddra !== 7'd127 || im1.IMena !== 1'b1) begin
      errors++; $display("FAIL wrap_addr_hi addr=%0d IMena=%b, expected 127 1", im1.IMaddra, im1.IMena);
    end
    tick();
    #1;
    checks++;
    if (im1.IMaddra !== 7'd0 || im1.IMena !== 1'b1) begin
      errors++; $display("FAIL wrap_addr_lo addr=%0d IMena=%b, expected 0 1", im1.IMaddra, im1.IMena);
    end
    tick();
    #1;
    checks++;
    if (pc1 !== 32'h1FC || inst1 !== 32'd127) begin
      errors++; $display("FAIL wrap_head0 pc=%h inst=%h, expected 1fc 7f", pc1, inst1);
    end
    tick();
    #1;
    checks++;
    if (pc1 !== 32'h200 || inst1 !== 32'd0) begin
      errors++; $display("FAIL wrap_head1 pc=%h inst=%h, expected 200 0", pc1, inst1);
    end
    for (int c = 0; c < 4; c++) tick();
    rst1 = 1'b1;
    tick();
  endtask

  task automatic test_latency3();
    rst3 = 1'b0;
    sb_load3(32'h0);
    for (int c = 0; c < 13; c++) begin
      #1;
      checks++;
      if (valid3 !== (c >= 4)) begin
        errors++; $display("FAIL lat3_valid cycle=%0d got=%b expected=%b", c, valid3, c >= 4);
      end
      if (c < 4) begin
        checks++;
        if (im3.IMena !== 1'b1) begin
          errors++; $display("FAIL lat3_fill_issue cycle=%0d IMena=%b expected 1", c, im3.IMena);
        end
      end
      if (c == 4) begin
        checks++;
        if (inst3 !== 32'h0 || pc3 !== 32'h0) begin
          errors++; $display("FAIL lat3_first inst=%h pc=%h, expected 0 0", inst3, pc3);
        end
      end
      tick();
    end
  endtask

  task automatic test_periodic_stall3();
    for (int c = 0; c < 24; c++) begin
      stall3 = ((c % 4) == 3);
      #1;
      checks++;
      if (valid3 !== 1'b1) begin
        errors++; $display("FAIL lat3_stall_gap cycle=%0d valid=%b expected 1", c, valid3);
      end
      tick();
    end
    stall3 = 1'b0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_reset_mid3();
    rst3 = 1'b1;
    #1;
    checks++;
    if (valid3 !== 1'b0 || occ3 !== 3'd0 || im3.IMena !== 1'b0 || inst3 !== 32'h6800_0000) begin
      errors++;
      $display("FAIL mid_reset valid=%b occ=%0d IMena=%b inst=%h, expected 0 0 0 68000000", valid3, occ3, im3.IMena, inst3);
    end
    tick();
    rst3 = 1'b0;
    sb_load3(32'h0);
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (valid3 !== (c >= 4)) begin
        errors++; $display("FAIL mid_reset_valid cycle=%0d got=%b expected=%b", c, valid3, c >= 4);
      end
      tick();
    end
  endtask

  initial begin
    rst1 = 1'b1; stall1 = 1'b0; br1 = 1'b0; bpc1 = '0;
    rst3 = 1'b1; stall3 = 1'b0; br3 = 1'b0; bpc3 = '0;
    test_reset();
    test_release();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_latency3();
    test_periodic_stall3();
    test_reset_mid3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
